pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the `hold` input of every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) and the flush inputs of if_id/id_ex. Three hazard sources feed it: data-memory wait states, load-use dependencies and taken branches. A wait-state FSM with a timeout turns a hung memory into a sticky error, and a saturating counter records stall cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - ctrl_state_e : wait-state FSM encodings (CTRL_RUN / CTRL_MEM_WAIT / CTRL_ERR)
//   - HOLD_ENABLE / HOLD_DISABLE, FLUSH_ENABLE / FLUSH_DISABLE : control levels
//   - REG_ADDR, WRITE_DISABLE, ZERO_INST : pipeline-wide constants
//   - src_match() : one source-operand vs destination comparison
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR = 5;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'b00,
    CTRL_MEM_WAIT = 2'b01,
    CTRL_ERR      = 2'b10
  } ctrl_state_e;

  localparam logic HOLD_ENABLE   = 1'b1;
  localparam logic HOLD_DISABLE  = 1'b0;
  localparam logic FLUSH_ENABLE  = 1'b1;
  localparam logic FLUSH_DISABLE = 1'b0;

  // Bubble content loaded by a flushed pipeline register.
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_INST     = 32'h0000_0000;

  // True when a used source register equals the producer's destination.
  function automatic logic src_match(input logic                used,
                                     input logic [REG_ADDR-1:0] rs,
                                     input logic [REG_ADDR-1:0] rd);
    return used & (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard comparator.
// Ports:
//   i_idex_mem_r_ena : EX instruction is a load
//   i_idex_rd        : EX destination register
//   i_ifid_rs1/rs2   : ID source registers
//   i_ifid_rs1_used / i_ifid_rs2_used : ID instruction actually reads the source
//   o_load_use       : ID needs the load result before it exists
// -----------------------------------------------------------------------------
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                i_idex_mem_r_ena,
  input  logic [REG_ADDR-1:0] i_idex_rd,
  input  logic [REG_ADDR-1:0] i_ifid_rs1,
  input  logic [REG_ADDR-1:0] i_ifid_rs2,
  input  logic                i_ifid_rs1_used,
  input  logic                i_ifid_rs2_used,
  output logic                o_load_use
);

  logic w_rd_nonzero;
  logic w_src_hit;

  // x0 is hard-wired zero, so a load to x0 never creates a dependency.
  assign w_rd_nonzero = (i_idex_rd != {REG_ADDR{1'b0}});
  assign w_src_hit    = src_match(i_ifid_rs1_used, i_ifid_rs1, i_idex_rd) |
                        src_match(i_ifid_rs2_used, i_ifid_rs2, i_idex_rd);
  assign o_load_use   = i_idex_mem_r_ena & w_rd_nonzero & w_src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller of the 5-stage pipeline.
// Ports:
//   clk_100MHz, arst_n (synchronous, active-low)
//   mem_req_i, mem_ready_i               : MEM-stage access handshake
//   idex_*/ifid_*                        : load-use operands
//   branch_taken_i                       : EX redirects the PC
//   hold_*_o                             : hold of pc/if_id/id_ex/ex_mem/mem_wb
//   flush_if_id_o, flush_id_ex_o         : insert a bubble
//   mem_timeout_err_o                    : sticky hung-memory flag
//   stall_cnt_o                          : saturating count of hold_pc cycles
// Hold/flush are combinational from registered state plus current inputs.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_100MHz,
  input  logic                   arst_n,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  input  logic                   idex_mem_r_ena_i,
  input  logic [REG_ADDR-1:0]    idex_rd_i,
  input  logic [REG_ADDR-1:0]    ifid_rs1_i,
  input  logic [REG_ADDR-1:0]    ifid_rs2_i,
  input  logic                   ifid_rs1_used_i,
  input  logic                   ifid_rs2_used_i,
  input  logic                   branch_taken_i,
  output logic                   hold_pc_o,
  output logic                   hold_if_id_o,
  output logic                   hold_id_ex_o,
  output logic                   hold_ex_mem_o,
  output logic                   hold_mem_wb_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   mem_timeout_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int                    WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_next;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_mem_stall;
  logic                   w_load_use;
  logic                   w_hold_pc;
  logic                   w_hold_if_id;
  logic                   w_hold_back;
  logic                   w_flush_if_id;
  logic                   w_flush_id_ex;

  load_use_detect u_load_use_detect (
    .i_idex_mem_r_ena (idex_mem_r_ena_i),
    .i_idex_rd        (idex_rd_i),
    .i_ifid_rs1       (ifid_rs1_i),
    .i_ifid_rs2       (ifid_rs2_i),
    .i_ifid_rs1_used  (ifid_rs1_used_i),
    .i_ifid_rs2_used  (ifid_rs2_used_i),
    .o_load_use       (w_load_use)
  );

  // FSM state register.
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      r_state <= CTRL_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; ready on the timeout cycle still returns to RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CTRL_RUN: begin
        if (mem_req_i & ~mem_ready_i) begin
          w_state_next = CTRL_MEM_WAIT;
        end else begin
          w_state_next = CTRL_RUN;
        end
      end
      CTRL_MEM_WAIT: begin
        if (mem_ready_i) begin
          w_state_next = CTRL_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = CTRL_ERR;
        end else begin
          w_state_next = CTRL_MEM_WAIT;
        end
      end
      CTRL_ERR: w_state_next = CTRL_ERR;
      // An unreachable encoding is treated as a fault: freeze the pipeline.
      default:  w_state_next = CTRL_ERR;
    endcase
  end

  // FSM output logic: memory freeze condition for the current cycle.
  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      CTRL_RUN:      w_mem_stall = mem_req_i & ~mem_ready_i;
      CTRL_MEM_WAIT: w_mem_stall = ~mem_ready_i;
      CTRL_ERR:      w_mem_stall = 1'b1;
      default:       w_mem_stall = 1'b1;
    endcase
  end

  // Priority mux: memory freeze, then branch flush, then load-use bubble.
  always_comb begin
    w_hold_pc     = HOLD_DISABLE;
    w_hold_if_id  = HOLD_DISABLE;
    w_hold_back   = HOLD_DISABLE;
    w_flush_if_id = FLUSH_DISABLE;
    w_flush_id_ex = FLUSH_DISABLE;
    if (w_mem_stall) begin
      // Frozen pipeline: branch/load-use re-evaluate from held registers later.
      w_hold_pc    = HOLD_ENABLE;
      w_hold_if_id = HOLD_ENABLE;
      w_hold_back  = HOLD_ENABLE;
    end else if (branch_taken_i) begin
      // The ID instruction is squashed, so any load-use against it is moot.
      w_flush_if_id = FLUSH_ENABLE;
      w_flush_id_ex = FLUSH_ENABLE;
    end else if (w_load_use) begin
      w_hold_pc     = HOLD_ENABLE;
      w_hold_if_id  = HOLD_ENABLE;
      w_flush_id_ex = FLUSH_ENABLE;
    end else begin
      w_hold_pc = HOLD_DISABLE;
    end
  end

  // Wait counter: 0 in RUN, steps once per cycle spent in MEM_WAIT.
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      r_wait_cnt <= {WAIT_W{1'b0}};
    end else if (w_state_next == CTRL_MEM_WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= {WAIT_W{1'b0}};
    end
  end

  // Saturating stall performance counter.
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      r_stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (w_hold_pc && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign hold_pc_o         = w_hold_pc;
  assign hold_if_id_o      = w_hold_if_id;
  assign hold_id_ex_o      = w_hold_back;
  assign hold_ex_mem_o     = w_hold_back;
  assign hold_mem_wb_o     = w_hold_back;
  assign flush_if_id_o     = w_flush_if_id;
  assign flush_id_ex_o     = w_flush_id_ex;
  assign mem_timeout_err_o = (r_state == CTRL_ERR);
  assign stall_cnt_o       = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a cycle-count based behavioural model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          mem_req_i, mem_ready_i, idex_mem_r_ena_i;
  logic [4:0]    idex_rd_i, ifid_rs1_i, ifid_rs2_i;
  logic          ifid_rs1_used_i, ifid_rs2_used_i, branch_taken_i;
  logic          hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o;
  logic          flush_if_id_o, flush_id_ex_o, mem_timeout_err_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive not-ready count, outstanding access, error, counter.
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  bit m_out   = 1'b0;
  int m_nr    = 0;
  int m_cnt   = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(CW)) dut (
    .clk_100MHz        (clk),
    .arst_n            (arst_n),
    .mem_req_i         (mem_req_i),
    .mem_ready_i       (mem_ready_i),
    .idex_mem_r_ena_i  (idex_mem_r_ena_i),
    .idex_rd_i         (idex_rd_i),
    .ifid_rs1_i        (ifid_rs1_i),
    .ifid_rs2_i        (ifid_rs2_i),
    .ifid_rs1_used_i   (ifid_rs1_used_i),
    .ifid_rs2_used_i   (ifid_rs2_used_i),
    .branch_taken_i    (branch_taken_i),
    .hold_pc_o         (hold_pc_o),
    .hold_if_id_o      (hold_if_id_o),
    .hold_id_ex_o      (hold_id_ex_o),
    .hold_ex_mem_o     (hold_ex_mem_o),
    .hold_mem_wb_o     (hold_mem_wb_o),
    .flush_if_id_o     (flush_if_id_o),
    .flush_id_ex_o     (flush_id_ex_o),
    .mem_timeout_err_o (mem_timeout_err_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic rdy, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic br);
    mem_req_i = req; mem_ready_i = rdy; idex_mem_r_ena_i = ld;
    idex_rd_i = rd; ifid_rs1_i = rs1; ifid_rs1_used_i = u1;
    ifid_rs2_i = rs2; ifid_rs2_used_i = u2; branch_taken_i = br;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Compare process: check outputs at each falling edge, then advance the model
  // to what the coming rising edge produces.
  initial begin
    bit ms, lu;
    bit [6:0] ev, av;
    forever begin
      @(negedge clk);
      ms = m_err || (m_out ? !mem_ready_i : (mem_req_i && !mem_ready_i));
      lu = idex_mem_r_ena_i && (idex_rd_i != 5'd0) &&
           ((ifid_rs1_used_i && ifid_rs1_i == idex_rd_i) ||
            (ifid_rs2_used_i && ifid_rs2_i == idex_rd_i));
      if (ms)                  ev = 7'b11111_00;
      else if (branch_taken_i) ev = 7'b00000_11;
      else if (lu)             ev = 7'b11000_01;
      else                     ev = 7'b00000_00;
      if (m_valid) begin
        av = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o,
              flush_if_id_o, flush_id_ex_o};
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL model_ctrl: got %b expected %b at %0t", av, ev, $time);
        end
        checks++;
        if (mem_timeout_err_o !== m_err) begin
          errors++;
          $display("FAIL model_err: got %b expected %b at %0t", mem_timeout_err_o, m_err, $time);
        end
        checks++;
        if (stall_cnt_o !== CW'(m_cnt)) begin
          errors++;
          $display("FAIL model_cnt: got %0d expected %0d at %0t", stall_cnt_o, m_cnt, $time);
        end
      end
      if (!arst_n) begin
        m_valid = 1'b1; m_err = 1'b0; m_out = 1'b0; m_nr = 0; m_cnt = 0;
      end else if (m_valid) begin
        if (!m_err) begin
          if (ms) begin
            m_nr++;
            m_out = 1'b1;
            if (m_nr >= TO) m_err = 1'b1;
          end else begin
            m_nr = 0;
            m_out = 1'b0;
          end
        end
        if (ev[6] && m_cnt < CMAX) m_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0;
    idle();
    tick(); tick();
    look();
    chk("rst_hold_pc", hold_pc_o, 0);
    chk("rst_flush_id_ex", flush_id_ex_o, 0);
    chk("rst_err", mem_timeout_err_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);

    // Load-use: load to x5, ID reads x5 via rs2.
    tick(); arst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
    look();
    chk("lu_hold_pc", hold_pc_o, 1);
    chk("lu_hold_if_id", hold_if_id_o, 1);
    chk("lu_flush_id_ex", flush_id_ex_o, 1);
    chk("lu_hold_id_ex", hold_id_ex_o, 0);
    chk("lu_flush_if_id", flush_if_id_o, 0);
    tick(); idle(); look();
    chk("lu_one_cycle", hold_pc_o, 0);
    chk("lu_cnt", stall_cnt_o, 1);

    // Load to x0 is never a hazard.
    tick(); drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); look();
    chk("x0_hold_pc", hold_pc_o, 0);
    chk("x0_flush_id_ex", flush_id_ex_o, 0);

    // Branch together with load-use: flushes only.
    tick(); drive(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd1, 1'b0, 1'b1); look();
    chk("br_flush_if_id", flush_if_id_o, 1);
    chk("br_flush_id_ex", flush_id_ex_o, 1);
    chk("br_hold_pc", hold_pc_o, 0);
    chk("br_hold_if_id", hold_if_id_o, 0);
    chk("br_cnt", stall_cnt_o, 1);

    // Memory wait: 3 not-ready cycles, branch during the wait.
    tick(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); look();
    chk("mw1_hold_mem_wb", hold_mem_wb_o, 1);
    tick(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); look();
    chk("mw2_hold_ex_mem", hold_ex_mem_o, 1);
    chk("mw2_branch_ignored", flush_if_id_o, 0);
    tick(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); look();
    chk("mw3_hold_pc", hold_pc_o, 1);
    tick(); drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); look();
    chk("mw_release_hold", hold_pc_o, 0);
    chk("mw_release_flush", flush_if_id_o, 1);
    tick(); idle(); look();
    chk("mw_cnt", stall_cnt_o, 4);

    // Ready arriving on the timeout cycle returns to RUN.
    for (int k = 1; k <= 3; k++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); look();
      chk("rt_hold", hold_pc_o, 1);
    end
    tick(); drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); look();
    chk("rt_ready_wins", hold_pc_o, 0);
    tick(); idle(); look();
    chk("rt_no_err", mem_timeout_err_o, 0);
    chk("rt_cnt_sat", stall_cnt_o, 7);

    // Timeout: ready never arrives.
    for (int k = 1; k <= 6; k++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); look();
      chk("to_err", mem_timeout_err_o, (k >= 5) ? 1 : 0);
      chk("to_hold", hold_mem_wb_o, 1);
    end
    tick(); idle(); look();
    chk("err_sticky", mem_timeout_err_o, 1);
    chk("err_hold", hold_pc_o, 1);
    chk("err_cnt_sat", stall_cnt_o, 7);
    tick(); arst_n = 1'b0;
    tick(); arst_n = 1'b1; look();
    chk("rst_err_clear", mem_timeout_err_o, 0);
    chk("rst_cnt_clear", stall_cnt_o, 0);
    chk("rst_hold_clear", hold_pc_o, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      arst_n           = ($urandom_range(0, 99) != 0);
      mem_req_i        = $urandom_range(0, 1);
      mem_ready_i      = ($urandom_range(0, 9) < 6);
      idex_mem_r_ena_i = $urandom_range(0, 1);
      idex_rd_i        = 5'($urandom_range(0, 3));
      ifid_rs1_i       = 5'($urandom_range(0, 3));
      ifid_rs2_i       = 5'($urandom_range(0, 3));
      ifid_rs1_used_i  = $urandom_range(0, 1);
      ifid_rs2_used_i  = $urandom_range(0, 1);
      branch_taken_i   = ($urandom_range(0, 4) == 0);
    end
    tick();
    look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
